gate_net_frame_loader: RTL and testbench

//  Producer/consumer end of the combinational gate-network classifier interface (in_bits/out_bits).

---
 rtl/gate_net_pkg.sv | 42 ++++
 rtl/gate_net_onehot_decoder.sv | 24 ++
 rtl/gate_net_frame_loader.sv | 114 +++++++++++
 tb/tb_gate_net_frame_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_net_pkg.sv
// Shared defaults, loader state encoding and one-hot decode helper for the
// gate-network frame loader slice.
package gate_net_pkg;

  localparam int unsigned N_BITS_DEF = 49;
  localparam int unsigned N_OUT_DEF  = 2;
  localparam int unsigned DEC_MAX    = 64;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] cls;
    logic       tie;
  } decode_t;

  // Lowest set bit wins; anything other than exactly one set bit is a tie.
  function automatic decode_t onehot_decode(input logic [DEC_MAX-1:0] bits,
                                            input int unsigned n);
    decode_t     d;
    int unsigned ones;
    logic        found;
    d     = '0;
    ones  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < DEC_MAX; i++) begin
      if (i < n && bits[i]) begin
        ones++;
        if (!found) begin
          d.cls = 8'(i);
          found = 1'b1;
        end
      end
    end
    d.tie = (ones != 1);
    return d;
  endfunction

endpackage

// File: rtl/gate_net_onehot_decoder.sv
// Combinational class decoder: classifier output vector -> class index + tie flag.
module gate_net_onehot_decoder
  import gate_net_pkg::*;
#(
  parameter  int unsigned N_OUT = N_OUT_DEF,
  localparam int unsigned CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic [N_OUT-1:0] bits,
  output logic [CLS_W-1:0] cls,
  output logic             tie
);

  logic [DEC_MAX-1:0] ext;
  decode_t            d;

  always_comb begin
    ext             = '0;
    ext[N_OUT-1:0]  = bits;
    d               = onehot_decode(ext, N_OUT);
    cls             = CLS_W'(d.cls);
    tie             = d.tie;
  end

endmodule

// File: rtl/gate_net_frame_loader.sv
// Deserialises a 1-bit pixel stream into a frame for the combinational
// classifier, samples its response and returns the decoded class.
module gate_net_frame_loader
  import gate_net_pkg::*;
#(
  parameter  int unsigned N_BITS   = N_BITS_DEF,
  parameter  int unsigned N_OUT    = N_OUT_DEF,
  parameter  int unsigned EVAL_LAT = 1,
  localparam int unsigned CLS_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_data,
  input  logic              pix_sof,
  output logic [N_BITS-1:0] net_in_bits,
  input  logic [N_OUT-1:0]  net_out_bits,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CLS_W-1:0]  res_class,
  output logic [N_OUT-1:0]  res_raw,
  output logic              res_tie,
  output logic              frame_err
);

  localparam int unsigned      CNT_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned      EV_W     = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_BITS - 1);
  localparam logic [EV_W-1:0]  LAST_EV  = EV_W'(EVAL_LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [EV_W-1:0]   ev_cnt;
  logic [N_BITS-1:0] frame_q;
  logic [N_BITS-1:0] frame_d;
  logic [CNT_W-1:0]  wr_idx;
  logic              beat;
  logic              restart;
  logic [CLS_W-1:0]  dec_cls;
  logic              dec_tie;

  // Gated by rst so every output reads 0 while reset is held.
  assign pix_ready = (state == FILL) && !rst;
  assign beat      = pix_valid && pix_ready;
  assign restart   = pix_sof && (cnt != '0);
  assign wr_idx    = restart ? '0 : cnt;

  always_comb begin
    frame_d         = frame_q;
    frame_d[wr_idx] = pix_data;
  end

  gate_net_onehot_decoder #(.N_OUT(N_OUT)) u_dec (
    .bits (net_out_bits),
    .cls  (dec_cls),
    .tie  (dec_tie)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      ev_cnt      <= '0;
      frame_q     <= '0;
      net_in_bits <= '0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      res_raw     <= '0;
      res_tie     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (beat) begin
            frame_q   <= frame_d;
            frame_err <= restart;
            if (restart) begin
              cnt <= CNT_W'(1);
            end else if (cnt == LAST_PIX) begin
              // Only a completed frame ever reaches the classifier.
              cnt         <= '0;
              net_in_bits <= frame_d;
              ev_cnt      <= '0;
              state       <= EVAL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EVAL: begin
          if (ev_cnt == LAST_EV) begin
            res_raw   <= net_out_bits;
            res_class <= dec_cls;
            res_tie   <= dec_tie;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            ev_cnt <= ev_cnt + EV_W'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_net_frame_loader.sv
// Self-checking bench for gate_net_frame_loader with a behavioural classifier stub.
module tb_gate_net_frame_loader;

  localparam int unsigned NB = 49;
  localparam int unsigned NO = 2;
  localparam int unsigned EL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid, pix_ready, pix_data, pix_sof;
  logic [NB-1:0] net_in_bits;
  logic [NO-1:0] net_out_bits;
  logic          res_valid, res_ready, res_tie, frame_err;
  logic [0:0]    res_class;
  logic [NO-1:0] res_raw;
  logic [NO-1:0] stub_out;

  assign net_out_bits = stub_out;

  gate_net_frame_loader #(.N_BITS(NB), .N_OUT(NO), .EVAL_LAT(EL)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .net_in_bits  (net_in_bits),
    .net_out_bits (net_out_bits),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_class    (res_class),
    .res_raw      (res_raw),
    .res_tie      (res_tie),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB-1:0] exp_net;
    logic [0:0]    exp_cls;
    logic [NO-1:0] exp_raw;
    logic          exp_tie;
  } exp_t;

  typedef struct {
    logic [NB-1:0] frame;
    logic          sof0;
    logic [NO-1:0] stub;
    logic [NB-1:0] exp_net;
    logic [0:0]    exp_cls;
    logic          exp_tie;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send_beat(input logic d, input logic s);
    int n;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) chk("beat_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [NB-1:0] f, input logic sof0, output int t0);
    t0 = 0;
    for (int k = 0; k < NB; k++) begin
      send_beat(f[k], (k == 0) ? sof0 : 1'b0);
      if (k == 0) t0 = cyc;
    end
  endtask

  task automatic push_exp(input logic [NB-1:0] net, input logic [0:0] cls,
                          input logic [NO-1:0] raw, input logic tie);
    exp_t e;
    e.exp_net = net;
    e.exp_cls = cls;
    e.exp_raw = raw;
    e.exp_tie = tie;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm, output int rv);
    int n;
    n  = 0;
    rv = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk({nm, "_valid_timeout"}, 64'd0, 64'd1);
    rv = cyc;
  endtask

  task automatic check_front(input string nm, input bit pop);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q[0];
    if (pop) void'(sb_q.pop_front());
    chk({nm, "_net"},   64'(net_in_bits), 64'(e.exp_net));
    chk({nm, "_class"}, 64'(res_class),   64'(e.exp_cls));
    chk({nm, "_raw"},   64'(res_raw),     64'(e.exp_raw));
    chk({nm, "_tie"},   64'(res_tie),     64'(e.exp_tie));
  endtask

  task automatic take(input string nm);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(res_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(pix_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_pix_ready"}, 64'(pix_ready),   64'd0);
    chk({nm, "_res_valid"}, 64'(res_valid),   64'd0);
    chk({nm, "_net"},       64'(net_in_bits), 64'd0);
    chk({nm, "_class"},     64'(res_class),   64'd0);
    chk({nm, "_raw"},       64'(res_raw),     64'd0);
    chk({nm, "_tie"},       64'(res_tie),     64'd0);
    chk({nm, "_ferr"},      64'(frame_err),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t0, rv;
    logic [31:0]   kk;
    logic [NB-1:0] fa, fb;

    pix_valid = 1'b0;
    pix_data  = 1'b0;
    pix_sof   = 1'b0;
    res_ready = 1'b0;
    stub_out  = '0;

    vecs[0] = '{frame: '0, sof0: 1'b1, stub: 2'b10, exp_net: '0, exp_cls: 1'b1, exp_tie: 1'b0};
    vecs[1] = '{frame: '0, sof0: 1'b1, stub: 2'b01,
                exp_net: 49'h0_AAAA_AAAA_AAAA, exp_cls: 1'b0, exp_tie: 1'b0};
    for (int k = 0; k < NB; k++) begin
      kk = k;
      vecs[1].frame[k] = kk[0];
    end
    vecs[2] = '{frame: 49'h1_2345_6789_ABCD, sof0: 1'b0, stub: 2'b00,
                exp_net: 49'h1_2345_6789_ABCD, exp_cls: 1'b0, exp_tie: 1'b1};
    vecs[3] = '{frame: 49'h1_FFFF_FFFF_FFFF, sof0: 1'b1, stub: 2'b11,
                exp_net: 49'h1_FFFF_FFFF_FFFF, exp_cls: 1'b0, exp_tie: 1'b1};
    vecs[4] = '{frame: 49'h0_F0F0_0F0F_1234, sof0: 1'b1, stub: 2'b10,
                exp_net: 49'h0_F0F0_0F0F_1234, exp_cls: 1'b1, exp_tie: 1'b0};

    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    #1;
    chk("reset_release_ready", 64'(pix_ready), 64'd1);

    // Table-driven frames; latency of the first measured from the first accepted beat.
    for (int i = 0; i < 5; i++) begin
      stub_out = vecs[i].stub;
      push_exp(vecs[i].exp_net, vecs[i].exp_cls, vecs[i].stub, vecs[i].exp_tie);
      send_frame(vecs[i].frame, vecs[i].sof0, t0);
      wait_valid($sformatf("v%0d", i), rv);
      if (i == 0) chk("v0_latency", 64'(rv - t0), 64'(NB + EL - 1));
      check_front($sformatf("v%0d", i), 1'b1);
      take($sformatf("v%0d", i));
    end

    // Consumer stall: outputs held, no pixels accepted.
    fa = 49'h0_1357_9BDF_0246;
    stub_out = 2'b01;
    push_exp(fa, 1'b0, 2'b01, 1'b0);
    send_frame(fa, 1'b1, t0);
    wait_valid("stall", rv);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_pix_ready", c), 64'(pix_ready), 64'd0);
      chk($sformatf("stall%0d_valid", c), 64'(res_valid), 64'd1);
      check_front($sformatf("stall%0d", c), 1'b0);
    end
    void'(sb_q.pop_front());
    take("stall");

    // Early sof at beat 20 restarts the frame.
    fb = 49'h1_0F0F_3C3C_A5A5;
    stub_out = 2'b10;
    push_exp(fb, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 20; k++) send_beat(1'b1, (k == 0));
    send_beat(fb[0], 1'b1);
    chk("restart_ferr_hi", 64'(frame_err), 64'd1);
    chk("restart_net_held", 64'(net_in_bits), 64'(fa));
    for (int k = 1; k < NB; k++) begin
      send_beat(fb[k], 1'b0);
      if (k == 1)      chk("restart_ferr_lo", 64'(frame_err), 64'd0);
      if (k == NB - 2) chk("restart_not_done", 64'(pix_ready), 64'd1);
    end
    chk("restart_done", 64'(pix_ready), 64'd0);
    wait_valid("restart", rv);
    check_front("restart", 1'b1);
    take("restart");

    // Reset mid-frame at beat 30.
    for (int k = 0; k < 30; k++) send_beat(1'b1, (k == 0));
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    stub_out = 2'b01;
    push_exp(fa, 1'b0, 2'b01, 1'b0);
    send_frame(fa, 1'b1, t0);
    wait_valid("after_rst_mid", rv);
    check_front("after_rst_mid", 1'b1);
    take("after_rst_mid");

    // Reset while a result is pending discards it.
    stub_out = 2'b11;
    push_exp(fb, 1'b0, 2'b11, 1'b1);
    send_frame(fb, 1'b1, t0);
    wait_valid("rst_result", rv);
    rst = 1'b1;
    #1;
    check_all_zero("rst_result");
    void'(sb_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    stub_out = 2'b10;
    push_exp(vecs[4].frame, 1'b1, 2'b10, 1'b0);
    send_frame(vecs[4].frame, 1'b1, t0);
    wait_valid("after_rst_result", rv);
    check_front("after_rst_result", 1'b1);
    take("after_rst_result");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
